dpram_copy_engine: RTL
======================

DPRAM_COPY_ENGINE -- requirements
Module: dpram_copy_engine

Interface
REQ-001 SHALL have no parameters; fixed geometry is 64 words x 8 bits, 6-bit addresses.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-005 src_addr  input  6  first source word address; read via RAM port A.
REQ-006 dst_addr  input  6  first destination word address; written via RAM port B.
REQ-007 len  input  7  word count, 0..64; values above 64 SHALL be treated as 64.
REQ-008 busy  output  1  high while a copy is in progress.
REQ-009 done  output  1  one-cycle pulse when a copy completes.
REQ-010 addr_a / we_a / data_a  output  6/1/8  drive the RAM A port; we_a SHALL be constant 0 and data_a constant 0.
REQ-011 q_a  input  8  RAM A read data, valid one cycle after addr_a is presented with we_a=0.
REQ-012 addr_b / we_b / data_b  output  6/1/8  drive the RAM B port as write-only.
REQ-013 All outputs SHALL be driven from registers.

Function
REQ-014 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-015 IDLE: start=1 with len>0 -> RUN at that edge (E0): latch src, dst, len; busy=1; addr_a=src_addr.
REQ-016 IDLE: start=1 with len=0 -> DONE; no RAM write occurs.
REQ-017 RUN: addr_a SHALL present src+k after edge E_k, for k=0..N-1; after the last read it SHALL hold its value; RUN -> DRAIN after E_{N-1}.
REQ-018 Read-data capture: q_a sampled at E_{k+2} SHALL be element k.
REQ-019 Write issue: after E_{k+2}, the block SHALL drive we_b=1, addr_b=dst+k, data_b=element k for exactly one cycle, for k=0..N-1.
REQ-020 Writes SHALL be back-to-back: we_b high for N consecutive cycles.
REQ-021 DRAIN -> DONE after the cycle in which the last write (k=N-1) is driven.
REQ-022 DONE: done=1 and busy=0 for one cycle, then unconditionally -> IDLE.
REQ-023 Totals: for N>0, busy SHALL be high N+2 cycles, and done SHALL rise at edge E_{N+2}.
REQ-024 For len=0, done SHALL pulse in the cycle after start and busy SHALL remain 0.
REQ-025 Address arithmetic SHALL be modulo 64: src+k and dst+k wrap from 63 to 0.
REQ-026 start SHALL be ignored in RUN, DRAIN and DONE; src/dst/len changes after E0 SHALL have no effect.
REQ-027 Overlap, dst==src or dst at a lower address than src (mod-64 forward distance >= len): result SHALL equal a sequential forward copy.
REQ-028 Overlap with 0 < (dst-src) mod 64 < len: destination contents are unspecified, but the block SHALL still complete with exactly N writes and one done pulse.
REQ-029 we_b SHALL be 0 in IDLE and DONE.

Reset
REQ-030 Reset SHALL take effect asynchronously: state=IDLE; busy=0, done=0, we_b=0, addr_a=0, addr_b=0, data_b=0; all counters 0.
REQ-031 Reset asserted mid-copy SHALL abort the copy: no further writes and no done pulse; writes already committed remain.
REQ-032 After rst_n deasserts, the first start SHALL be honoured on the next edge.

Verification
REQ-033 Scenario 1: RAM preloaded so that ram[i]=i+8'h40; start with src=0, dst=32, len=4 -> we_b high 4 cycles; ram[32..35]=40,41,42,43; done at E6; busy high 6 cycles.
REQ-034 Scenario 2: src=62, dst=10, len=4 -> reads 62,63,0,1; writes 10..13 with those values (wrap).
REQ-035 Scenario 3: len=0 -> done 1 cycle after start; we_b never asserted; len=100 -> 64 writes, done at E66.
REQ-036 Scenario 4: start pulsed again during RUN with different src -> ignored; original copy completes; exactly one done pulse.
REQ-037 Scenario 5: rst_n low at E3 of a len=8 copy -> we_b=0 and busy=0 immediately; no done pulse; only dst+0 committed; a fresh start afterwards completes normally.
REQ-038 Scenario 6: src=5, dst=3, len=10 (downward overlap) -> ram[3..12] equals original ram[5..14].

Source files
------------

// File: rtl/dpram_copy_engine.sv
// dpram_copy_engine: copies up to 64 bytes inside a dual-port RAM,
// reading through port A and writing back through port B.
module dpram_copy_engine (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] src_addr,
  input  logic [5:0] dst_addr,
  input  logic [6:0] len,
  output logic       busy,
  output logic       done,
  output logic [5:0] addr_a,
  output logic       we_a,
  output logic [7:0] data_a,
  input  logic [7:0] q_a,
  output logic [5:0] addr_b,
  output logic       we_b,
  output logic [7:0] data_b
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0] state;
  logic [6:0] n;
  logic [6:0] rd_cnt;
  logic [5:0] dst_r;
  logic [5:0] wr_off;
  logic       rv1;
  logic       rv2;
  logic [6:0] n_in;

  assign we_a   = 1'b0;
  assign data_a = 8'd0;
  assign n_in   = (len > 7'd64) ? 7'd64 : len;

  // rv1: a read address is on port A this cycle
  // rv2: its data is on q_a this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      n      <= 7'd0;
      rd_cnt <= 7'd0;
      dst_r  <= 6'd0;
      wr_off <= 6'd0;
      rv1    <= 1'b0;
      rv2    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      addr_a <= 6'd0;
      addr_b <= 6'd0;
      we_b   <= 1'b0;
      data_b <= 8'd0;
    end else begin
      rv2  <= rv1;
      we_b <= rv2;
      if (rv2) begin
        addr_b <= dst_r + wr_off;
        data_b <= q_a;
        wr_off <= wr_off + 6'd1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (len == 7'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state  <= (n_in == 7'd1) ? DRAIN : RUN;
              n      <= n_in;
              addr_a <= src_addr;
              dst_r  <= dst_addr;
              rd_cnt <= 7'd1;
              wr_off <= 6'd0;
              rv1    <= 1'b1;
              busy   <= 1'b1;
            end
          end
        end
        RUN: begin
          addr_a <= addr_a + 6'd1;
          rd_cnt <= rd_cnt + 7'd1;
          rv1    <= 1'b1;
          if (rd_cnt + 7'd1 == n)
            state <= DRAIN;
        end
        DRAIN: begin
          rv1 <= 1'b0;
          if (!rv1 && !rv2) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
